// File: rtl/dpkt_pe_multi.sv
// Packet de-packetiser at the NoC-to-PE boundary: filters on destination,
// routes filter/ifmap/psum payloads to PE ports and issues row tokens.
module dpkt_pe_multi #(
  parameter int PAY_W    = 24,
  parameter int ADDR_W   = 4,
  parameter int MY_ADDR  = 0,
  parameter int FILTER_W = 8,
  parameter int IFMAP_W  = 1,
  parameter int KERNEL   = 3,
  parameter int NUM_ROWS = 3,
  localparam int PKT_W   = 2 + 2*ADDR_W + PAY_W,
  localparam int RW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int FW      = KERNEL*FILTER_W,
  localparam int IW      = KERNEL*KERNEL*IFMAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [PKT_W-1:0] pkt_data,
  output logic             filt_valid,
  input  logic             filt_ready,
  output logic [FW-1:0]    filt_data,
  output logic             ifm_valid,
  input  logic             ifm_ready,
  output logic [IW-1:0]    ifm_data,
  output logic             psum_valid,
  input  logic             psum_ready,
  output logic [PAY_W-1:0] psum_data,
  output logic             ctrl_valid,
  input  logic             ctrl_ready,
  output logic [RW:0]      ctrl_data,
  output logic             load_done,
  output logic             type_err,
  output logic [7:0]       drop_cnt,
  output logic             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid and data are held stable until that transfer.
  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [1:0] T_FILT = 2'b00;
  localparam logic [1:0] T_IFM  = 2'b01;
  localparam logic [1:0] T_PSUM = 2'b10;
  localparam logic [1:0] T_RSV  = 2'b11;
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);

  state_t            state;
  logic [1:0]        sel;
  logic              data_done;
  logic              ctrl_done;
  logic [RW-1:0]     frow, irow;
  logic              f_full, i_full;

  logic [1:0]        pkt_type;
  logic [ADDR_W-1:0] pkt_dst;
  logic [ADDR_W-1:0] pkt_src;
  logic [PAY_W-1:0]  payload;
  logic              unused_src;
  logic              accept;
  logic              data_hs, ctrl_hs;
  logic              data_done_n, ctrl_done_n;
  logic [RW-1:0]     frow_n, irow_n;
  logic              f_full_n, i_full_n;

  assign pkt_type   = pkt_data[PKT_W-1 -: 2];
  assign pkt_dst    = pkt_data[PKT_W-3 -: ADDR_W];
  assign pkt_src    = pkt_data[PKT_W-3-ADDR_W -: ADDR_W];
  assign payload    = pkt_data[PAY_W-1:0];
  assign unused_src = ^pkt_src;

  assign pkt_ready  = (state == IDLE);
  assign state_dbg  = (state == EMIT);
  assign accept     = pkt_valid && pkt_ready;

  // Valids decode from state and done flags so a completed side drops at once.
  assign filt_valid = (state == EMIT) && (sel == T_FILT) && !data_done;
  assign ifm_valid  = (state == EMIT) && (sel == T_IFM)  && !data_done;
  assign psum_valid = (state == EMIT) && (sel == T_PSUM) && !data_done;
  assign ctrl_valid = (state == EMIT) && !ctrl_done;

  assign data_hs = (filt_valid && filt_ready) || (ifm_valid && ifm_ready) ||
                   (psum_valid && psum_ready);
  assign ctrl_hs = ctrl_valid && ctrl_ready;
  assign data_done_n = data_done || data_hs;
  assign ctrl_done_n = ctrl_done || ctrl_hs;

  always_comb begin
    frow_n   = frow;
    irow_n   = irow;
    f_full_n = f_full;
    i_full_n = i_full;
    if (ctrl_hs) begin
      if (!ctrl_data[RW]) begin
        if (frow == ROW_LAST) begin
          frow_n   = '0;
          f_full_n = 1'b1;
        end else begin
          frow_n = frow + 1'b1;
        end
      end else begin
        if (irow == ROW_LAST) begin
          irow_n   = '0;
          i_full_n = 1'b1;
        end else begin
          irow_n = irow + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= T_FILT;
      data_done <= 1'b0;
      ctrl_done <= 1'b0;
      frow      <= '0;
      irow      <= '0;
      f_full    <= 1'b0;
      i_full    <= 1'b0;
      drop_cnt  <= '0;
      type_err  <= 1'b0;
      load_done <= 1'b0;
      filt_data <= '0;
      ifm_data  <= '0;
      psum_data <= '0;
      ctrl_data <= '0;
    end else begin
      type_err  <= 1'b0;
      load_done <= 1'b0;
      frow      <= frow_n;
      irow      <= irow_n;
      // A token that completes both loads pulses load_done and rearms the flags.
      if (ctrl_hs && f_full_n && i_full_n) begin
        load_done <= 1'b1;
        f_full    <= 1'b0;
        i_full    <= 1'b0;
      end else begin
        f_full <= f_full_n;
        i_full <= i_full_n;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (pkt_dst != ADDR_W'(MY_ADDR) || pkt_type == T_RSV) begin
              if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
              type_err <= (pkt_dst == ADDR_W'(MY_ADDR));
            end else begin
              state     <= EMIT;
              sel       <= pkt_type;
              data_done <= 1'b0;
              ctrl_done <= (pkt_type == T_PSUM);
              case (pkt_type)
                T_FILT: begin
                  filt_data <= payload[FW-1:0];
                  ctrl_data <= {1'b0, frow};
                end
                T_IFM: begin
                  ifm_data  <= payload[IW-1:0];
                  ctrl_data <= {1'b1, irow};
                end
                default: psum_data <= payload;
              endcase
            end
          end
        end
        EMIT: begin
          data_done <= data_done_n;
          ctrl_done <= ctrl_done_n;
          if (data_done_n && ctrl_done_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpkt_pe_multi.sv
// Directed bench for dpkt_pe_multi: vector table plus hand-written
// sequences for backpressure, back-to-back drops and reset during EMIT.
module tb_dpkt_pe_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [33:0] pkt_data;
  logic        filt_valid, filt_ready;
  logic [23:0] filt_data;
  logic        ifm_valid, ifm_ready;
  logic [8:0]  ifm_data;
  logic        psum_valid, psum_ready;
  logic [23:0] psum_data;
  logic        ctrl_valid, ctrl_ready;
  logic [2:0]  ctrl_data;
  logic        load_done, type_err;
  logic [7:0]  drop_cnt;
  logic        state_dbg;

  dpkt_pe_multi dut (
    .clk(clk), .reset(reset),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_data(ctrl_data),
    .load_done(load_done), .type_err(type_err), .drop_cnt(drop_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  dst;
    logic [23:0] pay;
    int          port;      // 0 filt, 1 ifm, 2 psum, 3 dropped
    logic [23:0] exp_data;
    logic [2:0]  exp_ctrl;
    logic [7:0]  exp_drop;
    logic        exp_terr;
    logic        exp_ld;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: every ctrl transfer must match the next expected token
  always @(negedge clk) begin
    if (!reset && ctrl_valid && ctrl_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ctrl_unexpected actual=%0h expected=none", ctrl_data);
      end else begin
        check("ctrl_token", {29'd0, ctrl_data}, {29'd0, exp_q.pop_front()});
      end
    end
    if (!reset && load_done) ld_cnt++;
  end

  // driver: waits for pkt_ready, presents one packet for one accepting edge,
  // returns at the negedge of the cycle after acceptance
  task automatic send(input logic [1:0] typ, input logic [3:0] dst, input logic [23:0] pay);
    int n = 0;
    @(negedge clk);
    while (!pkt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pkt_ready) begin
      checks++;
      errors++;
      $display("FAIL pkt_ready_timeout actual=0 expected=1");
    end
    @(posedge clk); #1;
    pkt_valid = 1'b1;
    pkt_data  = {typ, dst, 4'h3, pay};
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    if (v.port < 2) exp_q.push_back(v.exp_ctrl);
    send(v.typ, v.dst, v.pay);
    check({tag, "_filt_valid"}, {31'd0, filt_valid}, {31'd0, v.port == 0});
    check({tag, "_ifm_valid"},  {31'd0, ifm_valid},  {31'd0, v.port == 1});
    check({tag, "_psum_valid"}, {31'd0, psum_valid}, {31'd0, v.port == 2});
    check({tag, "_ctrl_valid"}, {31'd0, ctrl_valid}, {31'd0, v.port < 2});
    case (v.port)
      0: check({tag, "_filt_data"}, {8'd0, filt_data}, {8'd0, v.exp_data});
      1: check({tag, "_ifm_data"},  {23'd0, ifm_data}, {8'd0, v.exp_data});
      2: check({tag, "_psum_data"}, {8'd0, psum_data}, {8'd0, v.exp_data});
      default: ;
    endcase
    if (v.port < 2) check({tag, "_ctrl_data"}, {29'd0, ctrl_data}, {29'd0, v.exp_ctrl});
    check({tag, "_pkt_ready1"}, {31'd0, pkt_ready}, {31'd0, v.port == 3});
    check({tag, "_drop_cnt"},   {24'd0, drop_cnt},  {24'd0, v.exp_drop});
    check({tag, "_type_err"},   {31'd0, type_err},  {31'd0, v.exp_terr});
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_pkt_ready2"}, {31'd0, pkt_ready}, 32'd1);
    check({tag, "_valids2"},
          {28'd0, filt_valid, ifm_valid, psum_valid, ctrl_valid}, 32'd0);
    check({tag, "_load_done"},  {31'd0, load_done}, {31'd0, v.exp_ld});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         typ    dst   pay        port data        ctrl    drop  terr  ld
    vecs[0] = '{2'b00, 4'd0, 24'h030201, 0, 24'h030201, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 4'd0, 24'h000011, 0, 24'h000011, 3'b001, 8'd0, 1'b0, 1'b0};
    vecs[2] = '{2'b00, 4'd0, 24'h000022, 0, 24'h000022, 3'b010, 8'd0, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 4'd0, 24'h0001A5, 1, 24'h0001A5, 3'b100, 8'd0, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 4'd0, 24'hABC1A5, 1, 24'h0001A5, 3'b101, 8'd0, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 4'd0, 24'h0001A5, 1, 24'h0001A5, 3'b110, 8'd0, 1'b0, 1'b1};
    vecs[6] = '{2'b10, 4'd0, 24'hABCDEF, 2, 24'hABCDEF, 3'b000, 8'd0, 1'b0, 1'b0};
    vecs[7] = '{2'b00, 4'd5, 24'h111111, 3, 24'h000000, 3'b000, 8'd1, 1'b0, 1'b0};
    vecs[8] = '{2'b11, 4'd0, 24'h222222, 3, 24'h000000, 3'b000, 8'd2, 1'b1, 1'b0};
    vecs[9] = '{2'b00, 4'd0, 24'h0000AA, 0, 24'h0000AA, 3'b000, 8'd2, 1'b0, 1'b0};

    reset = 1'b1;
    pkt_valid = 1'b0;
    pkt_data = '0;
    filt_ready = 1'b1;
    ifm_ready = 1'b1;
    psum_ready = 1'b1;
    ctrl_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
    check("rst_valids", {26'd0, filt_valid, ifm_valid, psum_valid, ctrl_valid,
                         load_done, type_err}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rst_state", {31'd0, state_dbg}, 32'd0);

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);
    check("load_done_count", ld_cnt, 32'd1);

    // back-to-back drops: wrong destination, then reserved type
    @(posedge clk); #1;
    pkt_valid = 1'b1;
    pkt_data  = {2'b00, 4'd5, 4'h0, 24'h0};
    @(posedge clk); #1;
    pkt_data  = {2'b11, 4'd0, 4'h0, 24'h0};
    @(negedge clk);
    check("b2b_drop1_cnt", {24'd0, drop_cnt}, 32'd3);
    check("b2b_drop1_terr", {31'd0, type_err}, 32'd0);
    check("b2b_drop1_ready", {31'd0, pkt_ready}, 32'd1);
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    @(negedge clk);
    check("b2b_drop2_cnt", {24'd0, drop_cnt}, 32'd4);
    check("b2b_drop2_terr", {31'd0, type_err}, 32'd1);
    check("b2b_valids", {28'd0, filt_valid, ifm_valid, psum_valid, ctrl_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_terr_pulse", {31'd0, type_err}, 32'd0);

    // ifmap with data backpressure: ctrl completes first, data held stable
    ifm_ready = 1'b0;
    exp_q.push_back(3'b100);
    send(2'b01, 4'd0, 24'h000155);
    check("bp_ifm_valid0", {31'd0, ifm_valid}, 32'd1);
    check("bp_ctrl_valid0", {31'd0, ctrl_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("bp_ifm_valid_c%0d", i), {31'd0, ifm_valid}, 32'd1);
      check($sformatf("bp_ifm_data_c%0d", i), {23'd0, ifm_data}, 32'h155);
      check($sformatf("bp_ctrl_valid_c%0d", i), {31'd0, ctrl_valid}, 32'd0);
      check($sformatf("bp_pkt_ready_c%0d", i), {31'd0, pkt_ready}, 32'd0);
    end
    @(posedge clk); #1;
    ifm_ready = 1'b1;
    @(negedge clk);
    check("bp_pkt_ready_hold", {31'd0, pkt_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_pkt_ready_done", {31'd0, pkt_ready}, 32'd1);
    check("bp_ifm_valid_done", {31'd0, ifm_valid}, 32'd0);

    // psum leaves row counters alone; reset during EMIT discards the packet
    filt_ready = 1'b0;
    ctrl_ready = 1'b0;
    send(2'b00, 4'd0, 24'h123456);
    check("rm_filt_valid", {31'd0, filt_valid}, 32'd1);
    check("rm_ctrl_data", {29'd0, ctrl_data}, 32'b001);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rm_valids", {26'd0, filt_valid, ifm_valid, psum_valid, ctrl_valid,
                        load_done, type_err}, 32'd0);
    check("rm_pkt_ready", {31'd0, pkt_ready}, 32'd1);
    check("rm_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rm_data", {filt_data[7:0], ifm_data[7:0], psum_data[7:0], 5'd0, ctrl_data}, 32'd0);
    filt_ready = 1'b1;
    ctrl_ready = 1'b1;
    exp_q.push_back(3'b000);
    send(2'b00, 4'd0, 24'h000777);
    check("rm_next_ctrl", {29'd0, ctrl_data}, 32'd0);
    check("rm_next_filt", {8'd0, filt_data}, 32'h000777);
    @(posedge clk); #1;
    @(negedge clk);

    check("exp_q_empty", exp_q.size(), 32'd0);
    check("load_done_total", ld_cnt, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
